// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared widths, flag positions, state encoding and lane helpers
package mem_access_ctrl_pkg;
  localparam int XLEN           = 32;
  localparam int XREG_ADDRWIDTH = 5;

  localparam int LB_BIT  = 0;
  localparam int LH_BIT  = 1;
  localparam int LW_BIT  = 2;
  localparam int LBU_BIT = 3;
  localparam int LHU_BIT = 4;

  localparam int SB_BIT = 0;
  localparam int SH_BIT = 1;
  localparam int SW_BIT = 2;

  localparam logic [4:0] NO_LOAD  = 5'b00000;
  localparam logic [2:0] NO_STORE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] calc_be(input logic half, input logic word, input logic [1:0] ofs);
    if (word) return 4'b1111;
    if (half) return 4'b0011 << ofs;
    return 4'b0001 << ofs;
  endfunction

  // Replicating the store value across lanes lets the bus pick bytes with dbus_be alone.
  function automatic logic [XLEN-1:0] lane_replicate(input logic half, input logic word,
                                                     input logic [XLEN-1:0] d);
    if (word) return d;
    if (half) return {2{d[15:0]}};
    return {4{d[7:0]}};
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - data bus request/ack interface
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// rtl/mem_access_ctrl_load_extend.sv - selects the addressed load lane and sign/zero extends it
module load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_lane,
  input  logic [4:0]      i_load_flag,
  output logic [XLEN-1:0] o_data
);
  logic [XLEN-1:0] w_lane;

  assign w_lane = i_data >> {i_lane, 3'b000};

  always_comb begin
    o_data = w_lane;
    if (i_load_flag[LB_BIT])
      o_data = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
    else if (i_load_flag[LBU_BIT])
      o_data = {{(XLEN-8){1'b0}}, w_lane[7:0]};
    else if (i_load_flag[LH_BIT])
      o_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
    else if (i_load_flag[LHU_BIT])
      o_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer: IDLE -> BUSY (bus request) -> DONE
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           rd_in,
  input  logic                      rd_en_in,
  input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
  input  logic [4:0]                load_flag_in,
  input  logic [2:0]                store_flag_in,
  input  logic [XLEN-1:0]           store_data_in,
  mem_access_ctrl_if.master         dbus,
  output logic                      stall_req,
  output logic [XLEN-1:0]           rd_out,
  output logic                      rd_en_out,
  output logic [XREG_ADDRWIDTH-1:0] rd_addr_out,
  output logic                      misalign_err,
  output logic                      bus_err
);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e                      r_state;
  logic                        r_req;
  logic                        r_we;
  logic [XLEN-1:0]             r_addr;
  logic [XLEN-1:0]             r_wdata;
  logic [3:0]                  r_be;
  logic [XLEN-1:0]             r_rdata;
  logic [4:0]                  r_load_flag;
  logic [1:0]                  r_lane;
  logic                        r_rd_en;
  logic [XREG_ADDRWIDTH-1:0]   r_rd_addr;
  logic [7:0]                  r_cnt;
  logic                        r_bus_err;

  logic                        w_is_load;
  logic                        w_is_store;
  logic                        w_mem_op;
  logic                        w_half;
  logic                        w_word;
  logic                        w_misalign;
  logic                        w_start;
  logic [7:0]                  w_cnt_next;
  logic [XLEN-1:0]             w_ext;

  assign w_is_load  = (load_flag_in != NO_LOAD);
  assign w_is_store = (store_flag_in != NO_STORE);
  assign w_mem_op   = w_is_load | w_is_store;
  assign w_half     = load_flag_in[LH_BIT] | load_flag_in[LHU_BIT] | store_flag_in[SH_BIT];
  assign w_word     = load_flag_in[LW_BIT] | store_flag_in[SW_BIT];
  assign w_misalign = (w_is_load & w_is_store) | (w_half & rd_in[0]) |
                      (w_word & (rd_in[1:0] != 2'b00));
  assign w_start    = (r_state == ST_IDLE) & w_mem_op & ~w_misalign;
  assign w_cnt_next = r_cnt + 8'd1;

  load_extend u_load_extend (
    .i_data      (r_rdata),
    .i_lane      (r_lane),
    .i_load_flag (r_load_flag),
    .o_data      (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= 4'b0000;
      r_rdata     <= '0;
      r_load_flag <= NO_LOAD;
      r_lane      <= 2'b00;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_cnt       <= 8'd0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_BUSY;
            r_req       <= 1'b1;
            r_we        <= w_is_store;
            r_addr      <= {rd_in[XLEN-1:2], 2'b00};
            r_be        <= calc_be(w_half, w_word, rd_in[1:0]);
            r_wdata     <= lane_replicate(w_half, w_word, store_data_in);
            r_load_flag <= load_flag_in;
            r_lane      <= rd_in[1:0];
            r_rd_en     <= rd_en_in;
            r_rd_addr   <= rd_addr_in;
            r_cnt       <= 8'd0;
          end
        end
        ST_BUSY: begin
          // An ack arriving on the last permitted cycle still completes normally.
          if (dbus.ack) begin
            r_req   <= 1'b0;
            r_rdata <= dbus.rdata;
            r_state <= ST_DONE;
          end else if (w_cnt_next == TIMEOUT_CNT) begin
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
            r_cnt     <= w_cnt_next;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_out       = rd_in;
    rd_en_out    = rd_en_in;
    rd_addr_out  = rd_addr_in;
    stall_req    = 1'b0;
    misalign_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          rd_en_out    = 1'b0;
          misalign_err = w_misalign;
          stall_req    = ~w_misalign;
        end
      end
      ST_BUSY: begin
        rd_en_out = 1'b0;
        stall_req = 1'b1;
      end
      ST_DONE: begin
        rd_out      = w_ext;
        rd_addr_out = r_rd_addr;
        rd_en_out   = (r_load_flag != NO_LOAD) & r_rd_en & ~r_bus_err;
      end
      default: ;
    endcase
  end

  assign dbus.req   = r_req;
  assign dbus.we    = r_we;
  assign dbus.addr  = r_addr;
  assign dbus.wdata = r_wdata;
  assign dbus.be    = r_be;
  assign bus_err    = r_bus_err;
endmodule
